// File: rtl/spi_transaction_sequencer.sv
// spi_transaction_sequencer: loads TX words into SPI controller memory, triggers a transfer, waits, reads back RX words
module spi_transaction_sequencer #(
    parameter int MEM_DEPTH      = 64,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        axi_clk,
    input  logic        axi_resetn,
    input  logic [31:0] cmd_len,
    input  logic        cmd_start,
    input  logic        cmd_abort,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        busy,
    output logic        done,
    output logic        err_len,
    output logic        err_timeout,
    output logic        aborted,
    output logic [31:0] ctl_mem_write,
    output logic        ctl_mem_write_strb,
    output logic        ctl_mem_write_ptr_reset,
    input  logic [31:0] ctl_mem_read,
    output logic        ctl_mem_read_strb,
    output logic        ctl_mem_read_ptr_reset,
    output logic [31:0] ctl_spi_len,
    output logic        ctl_spi_strb,
    input  logic [2:0]  ctl_status
);
    localparam int          NW      = ($clog2(MEM_DEPTH + 1) > 6) ? $clog2(MEM_DEPTH + 1) : 6;
    localparam logic [32:0] MAX_LEN = 33'(32 * MEM_DEPTH);
    localparam logic [31:0] TMAX    = 32'(TIMEOUT_CYCLES - 1);

    // TRIG..FINISH are kept contiguous so ctl_spi_len can be decoded with one compare
    typedef enum logic [3:0] {
        IDLE, WCLR, LOAD, HOLD, TRIG, WAIT_DONE, WAIT_IDLE, RCLR, RGAP, READ, FINISH
    } state_t;

    state_t         state, state_n;
    logic [31:0]    len, wcnt;
    logic [NW-1:0]  n_words, words_loaded, words_read, n_calc;
    logic           bad_len, bad_ev, start_ok, load_hs, read_hs, read_load, abort_ev, timeout_ev;

    assign bad_len = (cmd_len == '0) || ({1'b0, cmd_len} > MAX_LEN);
    assign n_calc  = NW'(({1'b0, cmd_len} + 33'd31) >> 5);

    // next-state decode and single-cycle events
    always_comb begin
        state_n    = state;
        bad_ev     = 1'b0;
        start_ok   = 1'b0;
        load_hs    = 1'b0;
        read_hs    = 1'b0;
        read_load  = 1'b0;
        abort_ev   = 1'b0;
        timeout_ev = 1'b0;
        case (state)
            IDLE: if (cmd_start) begin
                bad_ev   = bad_len;
                start_ok = !bad_len;
                state_n  = bad_len ? IDLE : WCLR;
            end
            WCLR: begin
                abort_ev = cmd_abort;
                state_n  = cmd_abort ? IDLE : LOAD;
            end
            LOAD: if (cmd_abort) begin
                abort_ev = 1'b1;
                state_n  = IDLE;
            end else if (tx_valid && tx_ready) begin
                load_hs = 1'b1;
                state_n = HOLD;
            end
            HOLD: begin
                abort_ev = cmd_abort;
                state_n  = cmd_abort ? IDLE : (words_loaded == n_words) ? TRIG : LOAD;
            end
            TRIG: state_n = WAIT_DONE;
            WAIT_DONE: if (ctl_status[1:0] == 2'd2) state_n = WAIT_IDLE;
                else if (wcnt == TMAX) begin
                    timeout_ev = 1'b1;
                    state_n    = IDLE;
                end
            WAIT_IDLE: if (ctl_status == 3'b000) state_n = RCLR;
                else if (wcnt == TMAX) begin
                    timeout_ev = 1'b1;
                    state_n    = IDLE;
                end
            RCLR: begin
                abort_ev = cmd_abort;
                state_n  = cmd_abort ? FINISH : RGAP;
            end
            RGAP: begin
                abort_ev = cmd_abort;
                state_n  = (cmd_abort || words_read == n_words) ? FINISH : READ;
            end
            READ: if (cmd_abort) begin
                abort_ev = 1'b1;
                state_n  = FINISH;
            end else if (!rx_valid) read_load = 1'b1;
            else if (rx_ready) begin
                read_hs = 1'b1;
                state_n = RGAP;
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // state, counters and registered outputs
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state                   <= IDLE;
            len                     <= '0;
            wcnt                    <= '0;
            n_words                 <= '0;
            words_loaded            <= '0;
            words_read              <= '0;
            tx_ready                <= 1'b0;
            rx_data                 <= '0;
            rx_valid                <= 1'b0;
            busy                    <= 1'b0;
            done                    <= 1'b0;
            err_len                 <= 1'b0;
            err_timeout             <= 1'b0;
            aborted                 <= 1'b0;
            ctl_mem_write           <= '0;
            ctl_mem_write_strb      <= 1'b0;
            ctl_mem_write_ptr_reset <= 1'b0;
            ctl_mem_read_strb       <= 1'b0;
            ctl_mem_read_ptr_reset  <= 1'b0;
            ctl_spi_len             <= '0;
            ctl_spi_strb            <= 1'b0;
        end else begin
            state                   <= state_n;
            len                     <= start_ok ? cmd_len : len;
            n_words                 <= start_ok ? n_calc : n_words;
            wcnt                    <= (state_n != state) ? '0 : wcnt + 32'd1;
            words_loaded            <= start_ok ? '0 : words_loaded + NW'(load_hs);
            words_read              <= start_ok ? '0 : words_read + NW'(read_hs);
            tx_ready                <= state_n == LOAD;
            rx_data                 <= read_load ? ctl_mem_read : rx_data;
            rx_valid                <= read_load || (rx_valid && state_n == READ);
            busy                    <= state_n != IDLE;
            done                    <= bad_ev || timeout_ev || (abort_ev && state_n == IDLE) || state_n == FINISH;
            err_len                 <= bad_ev || (err_len && !start_ok);
            err_timeout             <= timeout_ev || (err_timeout && !start_ok);
            aborted                 <= abort_ev || (aborted && !start_ok);
            ctl_mem_write           <= load_hs ? tx_data : ctl_mem_write;
            ctl_mem_write_strb      <= load_hs;
            ctl_mem_write_ptr_reset <= state_n == WCLR;
            ctl_mem_read_strb       <= read_hs;
            ctl_mem_read_ptr_reset  <= state_n == RCLR;
            ctl_spi_len             <= (state_n >= TRIG) ? len : '0;
            ctl_spi_strb            <= state_n == TRIG;
        end
    end
endmodule

// File: tb/tb_spi_transaction_sequencer.sv
// tb_spi_transaction_sequencer: directed scenarios against a small SPI controller model
module tb_spi_transaction_sequencer;
    logic        axi_clk = 1'b0, axi_resetn = 1'b0;
    logic [31:0] cmd_len = '0, tx_data = '0, rx_data, ctl_mem_write, ctl_mem_read, ctl_spi_len;
    logic        cmd_start = 1'b0, cmd_abort = 1'b0, tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0;
    logic        busy, done, err_len, err_timeout, aborted;
    logic        ctl_mem_write_strb, ctl_mem_write_ptr_reset, ctl_mem_read_strb, ctl_mem_read_ptr_reset, ctl_spi_strb;
    logic [2:0]  ctl_status;

    int passed = 0, total = 0;

    always #5 axi_clk = ~axi_clk;

    spi_transaction_sequencer #(.MEM_DEPTH(64), .TIMEOUT_CYCLES(16)) dut (
        .axi_clk(axi_clk), .axi_resetn(axi_resetn),
        .cmd_len(cmd_len), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .done(done), .err_len(err_len), .err_timeout(err_timeout), .aborted(aborted),
        .ctl_mem_write(ctl_mem_write), .ctl_mem_write_strb(ctl_mem_write_strb),
        .ctl_mem_write_ptr_reset(ctl_mem_write_ptr_reset), .ctl_mem_read(ctl_mem_read),
        .ctl_mem_read_strb(ctl_mem_read_strb), .ctl_mem_read_ptr_reset(ctl_mem_read_ptr_reset),
        .ctl_spi_len(ctl_spi_len), .ctl_spi_strb(ctl_spi_strb), .ctl_status(ctl_status)
    );

    // controller model: write memory captured one cycle after strobe, readback words are C0DE0000+index
    logic [31:0] wmem [0:63];
    int          wptr = 0, rptr = 0, scnt = 0;
    logic        pend = 1'b0, stuck = 1'b0, pw_strb = 1'b0;
    logic [31:0] pw_data = '0, spi_len_seen = '0;
    int          n_wstrb = 0, n_wptr = 0, n_spi = 0, n_rptr = 0, n_rstrb = 0, n_done = 0;
    int          cyc = 0, t_spi = 0, t_done = 0, hold_bad = 0;

    assign ctl_mem_read = 32'hC0DE0000 + 32'(rptr);

    // controller model, status sequencer 1->2->0 and event monitors
    always @(posedge axi_clk) begin
        cyc  <= cyc + 1;
        pend <= ctl_mem_write_strb;
        if (ctl_mem_write_ptr_reset) wptr <= 0;
        else if (pend) begin
            wmem[wptr[5:0]] <= ctl_mem_write;
            wptr <= wptr + 1;
        end
        if (ctl_mem_read_ptr_reset) rptr <= 0;
        else if (ctl_mem_read_strb) rptr <= rptr + 1;
        if (!axi_resetn) begin
            ctl_status <= 3'b000;
            scnt <= 0;
        end else if (ctl_spi_strb) begin
            ctl_status <= 3'b101;
            scnt <= 3;
        end else if (scnt > 0) scnt <= scnt - 1;
        else if (ctl_status == 3'b101 && !stuck) begin
            ctl_status <= 3'b110;
            scnt <= 3;
        end else if (ctl_status == 3'b110) ctl_status <= 3'b000;
        n_wstrb <= n_wstrb + int'(ctl_mem_write_strb);
        n_wptr  <= n_wptr + int'(ctl_mem_write_ptr_reset);
        n_spi   <= n_spi + int'(ctl_spi_strb);
        n_rptr  <= n_rptr + int'(ctl_mem_read_ptr_reset);
        n_rstrb <= n_rstrb + int'(ctl_mem_read_strb);
        n_done  <= n_done + int'(done);
        if (ctl_spi_strb) begin
            t_spi <= cyc;
            spi_len_seen <= ctl_spi_len;
        end
        if (done) t_done <= cyc;
        pw_strb <= ctl_mem_write_strb;
        pw_data <= ctl_mem_write;
        if (pw_strb && (ctl_mem_write_strb || ctl_mem_write !== pw_data)) hold_bad <= hold_bad + 1;
    end

    logic [31:0] txw [0:3];
    logic [31:0] rxw [0:3];
    int          n_tx_taken = 0, rx_unstable = 0;
    logic        hung = 1'b0;

    // runs one command; ab_mode 1 = abort during TRIG/WAIT_DONE, 2 = abort when first RX word is offered
    task automatic xfer(input logic [31:0] len, input int ntx, input int gap, input int hold,
                        input int ab_mode, output int nrx);
        int idx = 0, gapc = 0, holdc = hold, abc = 0;
        logic lv = 1'b0, lr = 1'b0;
        logic [31:0] ld = '0;
        nrx = 0;
        hung = 1'b1;
        @(negedge axi_clk);
        cmd_len = len;
        cmd_start = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge axi_clk);
            cmd_start = 1'b0;
            cmd_abort = 1'b0;
            if (lv && !lr && rx_valid && rx_data !== ld) rx_unstable++;
            if (done) begin
                hung = 1'b0;
                break;
            end
            if (idx < ntx && gapc == 0) begin
                tx_valid = 1'b1;
                tx_data = txw[idx];
                if (tx_ready) begin
                    idx++;
                    gapc = gap;
                end
            end else begin
                tx_valid = 1'b0;
                if (gapc > 0) gapc--;
            end
            rx_ready = 1'b0;
            if (rx_valid) begin
                if (ab_mode == 2 && abc == 0) begin
                    cmd_abort = 1'b1;
                    abc = 1;
                end else if (holdc > 0) holdc--;
                else begin
                    rx_ready = 1'b1;
                    if (nrx < 4) rxw[nrx] = rx_data;
                    nrx++;
                    holdc = hold;
                end
            end
            if (ab_mode == 1 && ctl_spi_strb && abc == 0) begin
                cmd_abort = 1'b1;
                abc = 1;
            end else if (ab_mode == 1 && abc == 1) begin
                cmd_abort = 1'b1;
                abc = 2;
            end
            lv = rx_valid;
            lr = rx_ready;
            ld = rx_data;
        end
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        cmd_abort = 1'b0;
        n_tx_taken = idx;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge axi_clk);
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        total++; if ({done, err_len, err_timeout, aborted} !== 4'b0) $display("FAIL rst_status: got %b want 0000", {done, err_len, err_timeout, aborted}); else passed++;
        total++; if ({tx_ready, rx_valid, ctl_mem_write_strb, ctl_mem_write_ptr_reset, ctl_mem_read_strb, ctl_mem_read_ptr_reset, ctl_spi_strb} !== 7'b0)
            $display("FAIL rst_strobes: got %b want 0", {tx_ready, rx_valid, ctl_mem_write_strb, ctl_mem_write_ptr_reset, ctl_mem_read_strb, ctl_mem_read_ptr_reset, ctl_spi_strb}); else passed++;
        total++; if ({rx_data, ctl_mem_write, ctl_spi_len} !== 96'h0) $display("FAIL rst_data: got %h want 0", {rx_data, ctl_mem_write, ctl_spi_len}); else passed++;
        axi_resetn = 1'b1;
        repeat (2) @(negedge axi_clk);
        total++; if (busy !== 1'b0) $display("FAIL rst_idle_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_basic;
        int s_w = n_wstrb, s_s = n_spi, s_r = n_rstrb, s_d = n_done, s_h = hold_bad, nrx;
        txw[0] = 32'hA5A5A5A5;
        txw[1] = 32'h12345678;
        xfer(32'd64, 2, 0, 0, 0, nrx);
        total++; if (hung !== 1'b0) $display("FAIL basic_hung: got %b want 0", hung); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL basic_busy_finish: got %b want 1", busy); else passed++;
        @(negedge axi_clk);
        total++; if (busy !== 1'b0) $display("FAIL basic_busy_after: got %b want 0", busy); else passed++;
        total++; if (n_wstrb - s_w !== 2) $display("FAIL basic_wstrb: got %0d want 2", n_wstrb - s_w); else passed++;
        total++; if (n_spi - s_s !== 1) $display("FAIL basic_spi: got %0d want 1", n_spi - s_s); else passed++;
        total++; if (n_rstrb - s_r !== 2) $display("FAIL basic_rstrb: got %0d want 2", n_rstrb - s_r); else passed++;
        total++; if (n_done - s_d !== 1) $display("FAIL basic_done: got %0d want 1", n_done - s_d); else passed++;
        total++; if (hold_bad !== s_h) $display("FAIL basic_hold: got %0d want %0d", hold_bad, s_h); else passed++;
        total++; if (spi_len_seen !== 32'd64) $display("FAIL basic_spi_len: got %0d want 64", spi_len_seen); else passed++;
        total++; if (wmem[0] !== 32'hA5A5A5A5 || wmem[1] !== 32'h12345678) $display("FAIL basic_wmem: got %h %h want a5a5a5a5 12345678", wmem[0], wmem[1]); else passed++;
        total++; if (nrx !== 2) $display("FAIL basic_nrx: got %0d want 2", nrx); else passed++;
        total++; if (rxw[0] !== 32'hC0DE0000 || rxw[1] !== 32'hC0DE0001) $display("FAIL basic_rx: got %h %h want c0de0000 c0de0001", rxw[0], rxw[1]); else passed++;
        total++; if ({err_len, err_timeout, aborted, ctl_spi_len} !== 35'h0) $display("FAIL basic_idle_flags: got %h want 0", {err_len, err_timeout, aborted, ctl_spi_len}); else passed++;
    endtask

    task automatic test_len;
        int s_w, s_p, s_s, s_d, nrx;
        logic [31:0] bad [0:1];
        bad[0] = 32'd0;
        bad[1] = 32'd2049;
        for (int i = 0; i < 2; i++) begin
            s_w = n_wstrb + n_rstrb; s_p = n_wptr + n_rptr; s_s = n_spi; s_d = n_done;
            xfer(bad[i], 0, 0, 0, 0, nrx);
            total++; if ({hung, err_len, busy} !== 3'b010) $display("FAIL len_err%0d: got hung,err_len,busy=%b want 010", i, {hung, err_len, busy}); else passed++;
            @(negedge axi_clk);
            total++; if (n_wstrb + n_rstrb + n_wptr + n_rptr + n_spi - s_w - s_p - s_s !== 0) $display("FAIL len_strobes%0d: got %0d want 0", i, n_wstrb + n_rstrb + n_wptr + n_rptr + n_spi - s_w - s_p - s_s); else passed++;
            total++; if (n_done - s_d !== 1 || done !== 1'b0) $display("FAIL len_done%0d: got %0d,%b want 1,0", i, n_done - s_d, done); else passed++;
        end
        txw[0] = 32'h11111111; txw[1] = 32'h22222222; txw[2] = 32'h33333333;
        s_w = n_wstrb; s_s = n_rstrb;
        xfer(32'd33, 3, 0, 0, 0, nrx);
        @(negedge axi_clk);
        total++; if (n_tx_taken !== 2) $display("FAIL len33_tx: got %0d want 2", n_tx_taken); else passed++;
        total++; if (n_wstrb - s_w !== 2 || n_rstrb - s_s !== 2) $display("FAIL len33_strb: got w%0d r%0d want 2 2", n_wstrb - s_w, n_rstrb - s_s); else passed++;
        total++; if (nrx !== 2) $display("FAIL len33_nrx: got %0d want 2", nrx); else passed++;
        total++; if (err_len !== 1'b0) $display("FAIL len33_errclr: got %b want 0", err_len); else passed++;
    endtask

    task automatic test_stall;
        int s_w = n_wstrb, s_s = n_spi, s_h = hold_bad, s_u = rx_unstable, nrx;
        txw[0] = 32'hDEADBEEF;
        txw[1] = 32'hCAFEF00D;
        xfer(32'd64, 2, 5, 3, 0, nrx);
        @(negedge axi_clk);
        total++; if (hung !== 1'b0) $display("FAIL stall_hung: got %b want 0", hung); else passed++;
        total++; if (n_wstrb - s_w !== 2 || n_spi - s_s !== 1) $display("FAIL stall_strb: got w%0d s%0d want 2 1", n_wstrb - s_w, n_spi - s_s); else passed++;
        total++; if (wmem[0] !== 32'hDEADBEEF || wmem[1] !== 32'hCAFEF00D) $display("FAIL stall_wmem: got %h %h want deadbeef cafef00d", wmem[0], wmem[1]); else passed++;
        total++; if (hold_bad !== s_h) $display("FAIL stall_hold: got %0d want %0d", hold_bad, s_h); else passed++;
        total++; if (rx_unstable !== s_u) $display("FAIL stall_rx_stable: got %0d want %0d", rx_unstable, s_u); else passed++;
        total++; if (nrx !== 2 || rxw[0] !== 32'hC0DE0000 || rxw[1] !== 32'hC0DE0001) $display("FAIL stall_rx: got %0d %h %h want 2 c0de0000 c0de0001", nrx, rxw[0], rxw[1]); else passed++;
    endtask

    task automatic test_timeout;
        int s_r = n_rstrb, nrx;
        stuck = 1'b1;
        txw[0] = 32'h0BADF00D;
        xfer(32'd32, 1, 0, 0, 0, nrx);
        total++; if ({hung, err_timeout, busy} !== 3'b010) $display("FAIL to_flags: got hung,err_timeout,busy=%b want 010", {hung, err_timeout, busy}); else passed++;
        @(negedge axi_clk);
        total++; if (t_done - t_spi !== 17) $display("FAIL to_cycles: got %0d want 17", t_done - t_spi); else passed++;
        total++; if (nrx !== 0 || n_rstrb - s_r !== 0) $display("FAIL to_noread: got %0d %0d want 0 0", nrx, n_rstrb - s_r); else passed++;
        stuck = 1'b0;
        repeat (10) @(negedge axi_clk);
    endtask

    task automatic test_abort;
        int s_w = n_wstrb, s_s = n_spi, s_d = n_done, s_r, nrx;
        logic sent = 1'b0;
        txw[0] = 32'hAAAA0001; txw[1] = 32'hAAAA0002; txw[2] = 32'hAAAA0003;
        @(negedge axi_clk);
        cmd_len = 32'd96;
        cmd_start = 1'b1;
        hung = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge axi_clk);
            cmd_start = 1'b0;
            tx_valid = tx_ready && !sent;
            tx_data = txw[0];
            if (tx_valid) sent = 1'b1;
            else if (sent) begin
                hung = 1'b0;
                break;
            end
        end
        repeat (3) @(negedge axi_clk);
        cmd_abort = 1'b1;
        @(negedge axi_clk);
        cmd_abort = 1'b0;
        total++; if ({hung, done, aborted, busy, tx_ready} !== 5'b01100) $display("FAIL ab_load: got hung,done,aborted,busy,tx_ready=%b want 01100", {hung, done, aborted, busy, tx_ready}); else passed++;
        @(negedge axi_clk);
        total++; if (n_spi - s_s !== 0 || n_wstrb - s_w !== 1 || n_done - s_d !== 1) $display("FAIL ab_load_cnt: got s%0d w%0d d%0d want 0 1 1", n_spi - s_s, n_wstrb - s_w, n_done - s_d); else passed++;
        s_w = n_wstrb;
        @(negedge axi_clk);
        cmd_len = 32'd64;
        cmd_start = 1'b1;
        hung = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge axi_clk);
            cmd_start = 1'b0;
            if (tx_ready) begin
                tx_valid = 1'b1;
                cmd_abort = 1'b1;
                hung = 1'b0;
                break;
            end
        end
        @(negedge axi_clk);
        tx_valid = 1'b0;
        cmd_abort = 1'b0;
        repeat (2) @(negedge axi_clk);
        total++; if (hung !== 1'b0 || n_wstrb - s_w !== 0 || aborted !== 1'b1) $display("FAIL ab_vs_hs: got hung%b w%0d ab%b want 0 0 1", hung, n_wstrb - s_w, aborted); else passed++;
        s_s = n_spi;
        xfer(32'd64, 2, 0, 0, 1, nrx);
        @(negedge axi_clk);
        total++; if (hung !== 1'b0 || aborted !== 1'b0) $display("FAIL ab_wait_ignored: got hung%b aborted%b want 0 0", hung, aborted); else passed++;
        total++; if (nrx !== 2 || rxw[1] !== 32'hC0DE0001 || n_spi - s_s !== 1) $display("FAIL ab_wait_rx: got %0d %h s%0d want 2 c0de0001 1", nrx, rxw[1], n_spi - s_s); else passed++;
        s_r = n_rstrb;
        xfer(32'd64, 2, 0, 2, 2, nrx);
        total++; if ({hung, done, rx_valid, aborted, busy} !== 5'b01011) $display("FAIL ab_read: got hung,done,rx_valid,aborted,busy=%b want 01011", {hung, done, rx_valid, aborted, busy}); else passed++;
        @(negedge axi_clk);
        total++; if (nrx !== 0 || n_rstrb - s_r !== 0 || busy !== 1'b0) $display("FAIL ab_read_cnt: got %0d r%0d busy%b want 0 0 0", nrx, n_rstrb - s_r, busy); else passed++;
    endtask

    task automatic test_reset_mid;
        int s_s = n_spi, s_all, s_d, nrx;
        logic sent = 1'b0;
        stuck = 1'b1;
        txw[0] = 32'h5A5A5A5A;
        @(negedge axi_clk);
        cmd_len = 32'd32;
        cmd_start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge axi_clk);
            cmd_start = 1'b0;
            tx_valid = tx_ready && !sent;
            tx_data = txw[0];
            if (tx_valid) sent = 1'b1;
            if (n_spi != s_s) break;
        end
        tx_valid = 1'b0;
        total++; if (n_spi - s_s !== 1) $display("FAIL rm_reached_wait: got %0d want 1", n_spi - s_s); else passed++;
        repeat (3) @(negedge axi_clk);
        axi_resetn = 1'b0;
        #1;
        total++; if ({busy, done, ctl_spi_len, ctl_mem_write, rx_data} !== 98'h0) $display("FAIL rm_outputs: got %h want 0", {busy, done, ctl_spi_len, ctl_mem_write, rx_data}); else passed++;
        repeat (2) @(negedge axi_clk);
        axi_resetn = 1'b1;
        stuck = 1'b0;
        s_all = n_wstrb + n_wptr + n_spi + n_rptr + n_rstrb;
        repeat (6) @(negedge axi_clk);
        total++; if (n_wstrb + n_wptr + n_spi + n_rptr + n_rstrb - s_all !== 0 || busy !== 1'b0) $display("FAIL rm_quiet: got %0d busy%b want 0 0", n_wstrb + n_wptr + n_spi + n_rptr + n_rstrb - s_all, busy); else passed++;
        txw[0] = 32'h01020304;
        txw[1] = 32'h05060708;
        s_d = n_done;
        xfer(32'd64, 2, 0, 0, 0, nrx);
        @(negedge axi_clk);
        total++; if (hung !== 1'b0 || n_done - s_d !== 1) $display("FAIL rm_next_done: got hung%b d%0d want 0 1", hung, n_done - s_d); else passed++;
        total++; if (nrx !== 2 || rxw[0] !== 32'hC0DE0000 || wmem[1] !== 32'h05060708) $display("FAIL rm_next_data: got %0d %h %h want 2 c0de0000 05060708", nrx, rxw[0], wmem[1]); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len();
        test_stall();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/spi_transaction_sequencer.md
SPI_TRANSACTION_SEQUENCER -- requirements
Module: spi_transaction_sequencer

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 64, controller memory depth in 32b words.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, max axi_clk cycles allowed in each wait state.
REQ-003 SHALL have ports: axi_clk in 1 clock; axi_resetn in 1 reset, asynchronous, active-low.
REQ-004 SHALL have command ports: cmd_len in 32 transaction length in bits; cmd_start in 1 start pulse; cmd_abort in 1 abort request.
REQ-005 SHALL have TX stream: tx_data in 32 word to send; tx_valid in 1; tx_ready out 1.
REQ-006 SHALL have RX stream: rx_data out 32 readback word; rx_valid out 1; rx_ready in 1.
REQ-007 SHALL have status: busy out 1; done out 1 one-cycle completion pulse; err_len out 1 sticky; err_timeout out 1 sticky; aborted out 1 sticky.
REQ-008 SHALL have controller side: ctl_mem_write out 32; ctl_mem_write_strb out 1; ctl_mem_write_ptr_reset out 1; ctl_mem_read in 32; ctl_mem_read_strb out 1; ctl_mem_read_ptr_reset out 1; ctl_spi_len out 32; ctl_spi_strb out 1; ctl_status in 3 ({triggered, state[1:0]}, state 0=IDLE 1=TRANSACTION 2=DONE).

Function
REQ-009 SHALL be fully synchronous to axi_clk; all outputs registered.
REQ-010 SHALL implement states IDLE, WCLR, LOAD, HOLD, TRIG, WAIT_DONE, WAIT_IDLE, RCLR, READ, RGAP, FINISH.
REQ-011 IDLE: cmd_start high -> latch L=cmd_len, N=ceil(L/32) (6+ bit counter), clear sticky flags, go WCLR; cmd_start ignored in every other state.
REQ-012 cmd_start with L==0 or L>32*MEM_DEPTH SHALL set err_len, pulse done, stay IDLE, no controller strobes.
REQ-013 WCLR: ctl_mem_write_ptr_reset high exactly one cycle, then LOAD.
REQ-014 LOAD: tx_ready high; on tx_valid&tx_ready register word to ctl_mem_write, ctl_mem_write_strb high that next cycle, go HOLD; no tx_valid -> stall in LOAD indefinitely (no timeout).
REQ-015 HOLD: strb low, ctl_mem_write held stable one cycle (controller captures one cycle after strobe); words_loaded==N -> TRIG else LOAD.
REQ-016 tx_ready SHALL be low outside LOAD; at most N TX words consumed per command.
REQ-017 ctl_spi_len SHALL equal L from TRIG through FINISH, 0 in IDLE.
REQ-018 TRIG: ctl_spi_strb high exactly one cycle, then WAIT_DONE.
REQ-019 WAIT_DONE: exit to WAIT_IDLE when ctl_status[1:0]==2.
REQ-020 WAIT_IDLE: exit to RCLR when ctl_status==3'b000.
REQ-021 Each wait state SHALL use a cycle counter cleared on entry; reaching TIMEOUT_CYCLES -> set err_timeout, pulse done, IDLE.
REQ-022 RCLR: ctl_mem_read_ptr_reset high one cycle, then RGAP.
REQ-023 RGAP: one cycle for pointer settle; then READ if words_read<N else FINISH.
REQ-024 READ: rx_data<=ctl_mem_read, rx_valid high and held stable until rx_ready; on handshake ctl_mem_read_strb high one cycle, words_read++, go RGAP.
REQ-025 FINISH: done pulse one cycle, busy low next cycle, IDLE.
REQ-026 busy SHALL be high in every state except IDLE.
REQ-027 cmd_abort in WCLR/LOAD/HOLD -> set aborted, drop strobes/tx_ready, pulse done, IDLE, no ctl_spi_strb.
REQ-028 cmd_abort in TRIG/WAIT_DONE/WAIT_IDLE SHALL be ignored (in-flight SPI cannot be cancelled).
REQ-029 cmd_abort in RCLR/RGAP/READ -> set aborted, rx_valid low, FINISH; unread words discarded.
REQ-030 Simultaneous abort and handshake in LOAD/READ: abort wins, word not counted.

Reset
REQ-031 axi_resetn low SHALL force IDLE, all counters 0, all outputs 0 (including rx_data, ctl_mem_write, ctl_spi_len).
REQ-032 Reset mid-transaction SHALL abandon it with no further strobes after deassertion.

Verification
REQ-033 L=64, TX 0xA5A5A5A5,0x12345678, status model 1->2->0, rx_ready=1 -> two write strobes each followed by hold cycle, one spi_strb, ctl_spi_len=64, RX returns model words in order, done once.
REQ-034 L=33 -> N=2 words loaded/read; L=0 and L=32*MEM_DEPTH+1 -> err_len, done, no strobes.
REQ-035 tx_valid gapped 5 cycles between words, rx_ready low 3 cycles -> stall, data stable, no extra strobes.
REQ-036 TIMEOUT_CYCLES=16, status stuck at 1 -> err_timeout after 16 cycles in WAIT_DONE, done, busy low.
REQ-037 Abort after first of 3 words -> aborted set, no spi_strb; abort in WAIT_DONE ignored; abort in READ -> FINISH.
REQ-038 axi_resetn pulsed during WAIT_DONE -> all outputs 0, IDLE; next command runs normally.
